// File: rtl/trajectory_engine.sv
// Projectile trajectory stepper: launches from (x_pos,0), bounces off the side
// walls, optionally decelerates under gravity, and reports the first target hit.
module trajectory_engine #(
  parameter int W         = 5,
  parameter int XMAX      = 2**W - 1,
  parameter int YMAX      = 2**W - 1,
  parameter int MAX_STEPS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W-1:0]                 x_pos,
  input  logic [W-1:0]                 rise_in,
  input  logic [W-1:0]                 run_in,
  input  logic                         direction_in,
  input  logic                         grav_en,
  input  logic                         shoot,
  input  logic [W-1:0]                 target_x,
  input  logic [W-1:0]                 target_y,
  output logic                         busy,
  output logic                         result_valid,
  output logic                         hit,
  output logic [$clog2(MAX_STEPS)-1:0] hit_step,
  output logic [W-1:0]                 positionx,
  output logic [W-1:0]                 positiony
);

  localparam int SW = $clog2(MAX_STEPS);
  localparam logic [W-1:0]          XMAX_W    = W'(XMAX);
  localparam logic [W+1:0]          XMAX2     = (W+2)'(2 * XMAX);
  localparam logic signed [W+1:0]   YMAX_S    = (W+2)'(YMAX);
  localparam logic signed [W:0]     VY_MIN    = {1'b1, {W{1'b0}}};
  localparam logic signed [W:0]     VY_ONE    = (W+1)'(1);
  localparam logic [SW-1:0]         STEP_LAST = SW'(MAX_STEPS - 1);

  typedef enum logic [1:0] {IDLE, FLY, DONE} state_t;

  state_t                state, state_nxt;
  logic [W-1:0]          x, y, run;
  logic signed [W:0]     vy;
  logic                  dir, grav;
  logic [SW-1:0]         step;

  logic [W:0]            sum_r;
  logic [W-1:0]          x_nxt;
  logic                  dir_nxt;
  logic signed [W+1:0]   y_sum;
  logic                  end_flight;
  logic                  target_match;

  function automatic logic signed [W:0] vy_dec(input logic signed [W:0] v);
    if (v == VY_MIN) return v;
    return v - VY_ONE;
  endfunction

  function automatic logic [W-1:0] run_clip(input logic [W-1:0] r);
    return (r > XMAX_W) ? XMAX_W : r;
  endfunction

  // Next-step geometry: reflect off a wall only when the step overshoots it
  always_comb begin
    sum_r   = {1'b0, x} + {1'b0, run};
    x_nxt   = x;
    dir_nxt = dir;
    if (dir) begin
      if (sum_r > {1'b0, XMAX_W}) begin
        x_nxt   = W'(XMAX2 - {1'b0, sum_r});
        dir_nxt = 1'b0;
      end else begin
        x_nxt = sum_r[W-1:0];
      end
    end else begin
      if (run > x) begin
        x_nxt   = run - x;
        dir_nxt = 1'b1;
      end else begin
        x_nxt = x - run;
      end
    end
    y_sum        = $signed({2'b00, y}) + $signed({vy[W], vy});
    end_flight   = (y_sum < 0) || (y_sum > YMAX_S) || (step == STEP_LAST);
    target_match = (x == target_x) && (y == target_y);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: if (shoot) state_nxt = FLY;
      FLY: begin
        busy = 1'b1;
        if (end_flight) state_nxt = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x        <= '0;
      y        <= '0;
      vy       <= '0;
      run      <= '0;
      dir      <= 1'b0;
      grav     <= 1'b0;
      step     <= '0;
      hit      <= 1'b0;
      hit_step <= '0;
    end else begin
      case (state)
        IDLE: if (shoot) begin
          x        <= x_pos;
          y        <= '0;
          vy       <= $signed({1'b0, rise_in});
          run      <= run_clip(run_in);
          dir      <= direction_in;
          grav     <= grav_en;
          step     <= '0;
          hit      <= 1'b0;
          hit_step <= '0;
        end
        FLY: begin
          if (target_match && !hit) begin
            hit      <= 1'b1;
            hit_step <= step;
          end
          // The terminating cycle freezes position so the result shows the last in-bounds point
          if (!end_flight) begin
            x    <= x_nxt;
            y    <= y_sum[W-1:0];
            vy   <= grav ? vy_dec(vy) : vy;
            dir  <= dir_nxt;
            step <= step + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign positionx = x;
  assign positiony = y;

endmodule

// File: tb/tb_trajectory_engine.sv
// Bench for trajectory_engine: directed shots plus randomized shots, each checked
// cycle by cycle against an integer flight model of the projectile rules.
module tb_trajectory_engine;

  localparam int W         = 5;
  localparam int XMAX      = 31;
  localparam int YMAX      = 31;
  localparam int MAX_STEPS = 64;
  localparam int SW        = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  x_pos = '0, rise_in = '0, run_in = '0;
  logic          direction_in = 1'b0, grav_en = 1'b0, shoot = 1'b0;
  logic [W-1:0]  target_x = '0, target_y = '0;
  logic          busy, result_valid, hit;
  logic [SW-1:0] hit_step;
  logic [W-1:0]  positionx, positiony;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_x[$];
  int exp_y[$];
  bit m_hit;
  int m_step;

  int obs_x[$];
  int obs_y[$];
  int o_cyc;
  logic o_hit;
  logic [SW-1:0] o_step;

  trajectory_engine #(.W(W), .XMAX(XMAX), .YMAX(YMAX), .MAX_STEPS(MAX_STEPS)) dut (
    .clk(clk), .rst(rst),
    .x_pos(x_pos), .rise_in(rise_in), .run_in(run_in),
    .direction_in(direction_in), .grav_en(grav_en), .shoot(shoot),
    .target_x(target_x), .target_y(target_y),
    .busy(busy), .result_valid(result_valid), .hit(hit), .hit_step(hit_step),
    .positionx(positionx), .positiony(positiony)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Flight model: list of positions the projectile occupies, one per FLY cycle
  task automatic model(input int xp, input int rise, input int run0, input bit dr,
                       input bit gv, input int tx, input int ty);
    int x, y, vy, run, nx, ny;
    bit d;
    exp_x.delete();
    exp_y.delete();
    m_hit  = 0;
    m_step = 0;
    run = (run0 > XMAX) ? XMAX : run0;
    x = xp; y = 0; vy = rise; d = dr;
    for (int st = 0; st < MAX_STEPS; st++) begin
      exp_x.push_back(x);
      exp_y.push_back(y);
      if (!m_hit && x == tx && y == ty) begin
        m_hit  = 1;
        m_step = st;
      end
      ny = y + vy;
      if (ny < 0 || ny > YMAX || st == MAX_STEPS - 1) break;
      if (d) begin
        nx = x + run;
        if (nx > XMAX) begin nx = 2 * XMAX - nx; d = 0; end
      end else begin
        nx = x - run;
        if (nx < 0) begin nx = -nx; d = 1; end
      end
      x = nx;
      y = ny;
      if (gv && vy > -(1 << W)) vy = vy - 1;
    end
  endtask

  task automatic shot(input int xp, input int rise, input int run0, input bit dr,
                      input bit gv, input int tx, input int ty);
    int cyc;
    int last;
    model(xp, rise, run0, dr, gv, tx, ty);
    @(negedge clk);
    x_pos = W'(xp); rise_in = W'(rise); run_in = W'(run0);
    direction_in = dr; grav_en = gv;
    target_x = W'(tx); target_y = W'(ty);
    shoot = 1'b1;
    @(negedge clk);
    obs_x.delete();
    obs_y.delete();
    cyc = 0;
    while (!result_valid && cyc < MAX_STEPS + 4) begin
      chk("fly_busy", 32'(busy), 32'd1);
      obs_x.push_back(int'(positionx));
      obs_y.push_back(int'(positiony));
      if (cyc < exp_x.size()) begin
        chk("fly_x", 32'(positionx), 32'(exp_x[cyc]));
        chk("fly_y", 32'(positiony), 32'(exp_y[cyc]));
        chk("fly_hit", 32'(hit), 32'(m_hit && m_step < cyc));
      end
      shoot        = 1'($urandom_range(1, 0));
      x_pos        = W'($urandom_range(31, 0));
      rise_in      = W'($urandom_range(31, 0));
      run_in       = W'($urandom_range(31, 0));
      direction_in = 1'($urandom_range(1, 0));
      grav_en      = 1'($urandom_range(1, 0));
      cyc++;
      @(negedge clk);
    end
    o_cyc  = cyc;
    o_hit  = hit;
    o_step = hit_step;
    last   = exp_x.size() - 1;
    chk("fly_cycles", 32'(cyc), 32'(exp_x.size()));
    chk("done_valid", 32'(result_valid), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_hit", 32'(hit), 32'(m_hit));
    chk("done_hit_step", 32'(hit_step), 32'(m_hit ? m_step : 0));
    chk("done_x", 32'(positionx), 32'(exp_x[last]));
    chk("done_y", 32'(positiony), 32'(exp_y[last]));
    shoot = 1'b1;
    @(negedge clk);
    shoot = 1'b0;
    chk("idle_valid", 32'(result_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("idle_busy2", 32'(busy), 32'd0);
    chk("idle_hold_hit", 32'(hit), 32'(m_hit));
    chk("idle_hold_step", 32'(hit_step), 32'(m_hit ? m_step : 0));
    chk("idle_hold_x", 32'(positionx), 32'(exp_x[last]));
    chk("idle_hold_y", 32'(positiony), 32'(exp_y[last]));
  endtask

  initial begin
    int ytab[10];
    int xp, rs, rn, tx, ty, idx;
    bit dr, gv;
    ytab = '{0, 4, 7, 9, 10, 10, 9, 7, 4, 0};

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_hit_step", 32'(hit_step), 32'd0);
    chk("rst_x", 32'(positionx), 32'd0);
    chk("rst_y", 32'(positiony), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Straight rising shot through a target two steps out
    shot(10, 2, 3, 1'b1, 1'b0, 16, 4);
    chk("r029_hit", 32'(o_hit), 32'd1);
    chk("r029_hit_step", 32'(o_step), 32'd2);
    chk("r029_cycles", 32'(o_cyc), 32'd16);
    chk("r029_x2", 32'(obs_x[2]), 32'd16);
    chk("r029_y2", 32'(obs_y[2]), 32'd4);

    // Wall reflections
    shot(30, 1, 4, 1'b1, 1'b0, 0, 31);
    chk("r030_right_bounce", 32'(obs_x[1]), 32'd28);
    chk("r030_right_after", 32'(obs_x[2]), 32'd24);
    shot(2, 1, 5, 1'b0, 1'b0, 0, 31);
    chk("r030_left_bounce", 32'(obs_x[1]), 32'd3);
    chk("r030_left_after", 32'(obs_x[2]), 32'd8);
    shot(27, 1, 4, 1'b1, 1'b0, 0, 31);
    chk("r030_wall_land", 32'(obs_x[1]), 32'd31);

    // Gravity arc with target at the launch point, crossed again on landing
    shot(5, 4, 0, 1'b1, 1'b1, 5, 0);
    chk("r031_cycles", 32'(o_cyc), 32'd10);
    for (int i = 0; i < 10; i++) chk("r031_y", 32'(obs_y[i]), 32'(ytab[i]));
    chk("r031_x", 32'(obs_x[9]), 32'd5);
    chk("r034_hit", 32'(o_hit), 32'd1);
    chk("r034_hit_step", 32'(o_step), 32'd0);

    // Flat shot ends only on the step limit
    shot(7, 0, 3, 1'b1, 1'b0, 20, 9);
    chk("r032_cycles", 32'(o_cyc), 32'd64);
    chk("r032_hit", 32'(o_hit), 32'd0);

    // Asynchronous abort mid-flight
    @(negedge clk);
    x_pos = 5'd9; rise_in = 5'd0; run_in = 5'd1; direction_in = 1'b1; grav_en = 1'b0;
    target_x = 5'd9; target_y = 5'd0;
    shoot = 1'b1;
    @(posedge clk);
    #1 shoot = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_abort_x", 32'(positionx), 32'd14);
    chk("pre_abort_hit", 32'(hit), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(result_valid), 32'd0);
    chk("abort_hit", 32'(hit), 32'd0);
    chk("abort_hit_step", 32'(hit_step), 32'd0);
    chk("abort_x", 32'(positionx), 32'd0);
    chk("abort_y", 32'(positiony), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_no_valid", 32'(result_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_idle", 32'(busy), 32'd0);
    shot(12, 3, 2, 1'b0, 1'b1, 8, 5);

    // Randomized shots, half of them aimed at a point on their own path
    for (int n = 0; n < 24; n++) begin
      xp = $urandom_range(31, 0);
      rs = $urandom_range(31, 0);
      rn = $urandom_range(31, 0);
      dr = 1'($urandom_range(1, 0));
      gv = 1'($urandom_range(1, 0));
      tx = $urandom_range(31, 0);
      ty = $urandom_range(31, 0);
      if ($urandom_range(1, 0) == 1) begin
        model(xp, rs, rn, dr, gv, 99, 99);
        idx = $urandom_range(exp_x.size() - 1, 0);
        tx  = exp_x[idx];
        ty  = exp_y[idx];
      end
      shot(xp, rs, rn, dr, gv, tx, ty);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trajectory_engine.md
TRAJECTORY_ENGINE -- requirements
Module: trajectory_engine

Interface
REQ-001 SHALL have parameter W, default 5: coordinate and velocity magnitude width.
REQ-002 SHALL have parameter XMAX, default 2^W-1: right wall x coordinate; left wall is 0.
REQ-003 SHALL have parameter YMAX, default 2^W-1: ceiling y coordinate; floor is 0.
REQ-004 SHALL have parameter MAX_STEPS, default 64: step limit per shot.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have ports x_pos, rise_in, run_in, input, W bits each: launch x, vertical speed, horizontal speed.
REQ-008 SHALL have ports direction_in and grav_en, input, 1 bit each: 1 = launch right, 0 = left; 1 = gravity mode.
REQ-009 SHALL have port shoot, input, 1 bit: launch request, sampled only in IDLE.
REQ-010 SHALL have ports target_x and target_y, input, W bits each: target, compared live every FLY cycle.
REQ-011 SHALL have port busy, output, 1 bit: high in FLY and DONE.
REQ-012 SHALL have ports result_valid and hit, output, 1 bit each: 1-cycle DONE pulse; sticky hit flag.
REQ-013 SHALL have port hit_step, output, clog2(MAX_STEPS) bits: step index of the first hit.
REQ-014 SHALL have ports positionx and positiony, output, W bits each: current projectile position.

Function
REQ-015 SHALL implement states IDLE, FLY, DONE; busy = (state != IDLE).
REQ-016 IDLE: on shoot=1, SHALL load x=x_pos, y=0, step=0, run=min(run_in,XMAX), vy=+rise_in (W+1-bit signed), dir=direction_in, grav=grav_en, clear hit and hit_step, and enter FLY on the next edge.
REQ-017 shoot SHALL be ignored in FLY and DONE; launch inputs SHALL not be re-sampled after launch.
REQ-018 FLY, every cycle: if (x,y)==(target_x,target_y) and hit=0, SHALL set hit=1 and hit_step=step; the launch position at step 0 counts.
REQ-019 Horizontal step, right: s=x+run in W+1 bits; if s>XMAX then x'=2*XMAX-s and dir flips, else x'=s.
REQ-020 Horizontal step, left: if run>x then x'=run-x and dir flips, else x'=x-run; landing exactly on a wall SHALL NOT flip dir.
REQ-021 Vertical step: y'=y+vy, computed signed in W+2 bits; when grav=1, vy'=vy-1, saturating at -(2^W); when grav=0, vy is constant.
REQ-022 If y'<0, or y'>YMAX, or step==MAX_STEPS-1, SHALL enter DONE with x, y, and step left unchanged; otherwise SHALL update x, y, vy, dir and step=step+1.
REQ-023 The hit check of the final FLY cycle SHALL take effect together with the transition to DONE.
REQ-024 DONE SHALL last exactly one cycle, with result_valid=1, then return to IDLE.
REQ-025 hit, hit_step, positionx and positiony SHALL hold their values in IDLE until the next accepted shoot.
REQ-026 With rise_in=0 and grav_en=0, flight SHALL end only on the MAX_STEPS limit; with run_in=0, x SHALL stay constant.

Reset
REQ-027 While rst=0, SHALL asynchronously force state=IDLE and x, y, vy, run, dir, grav, step, hit and hit_step to 0; all outputs SHALL be 0.
REQ-028 Asserting rst mid-FLY SHALL abort the shot with no result_valid pulse; after release the block SHALL be in IDLE.

Verification (W=5, defaults)
REQ-029 x_pos=10, run=3, rise=2, right, grav=0, target (16,4) -> positions (10,0),(13,2),(16,4); hit=1 and hit_step=2; DONE follows step 15 (y=30, y'=32>31); result_valid=1 for one cycle only.
REQ-030 x_pos=30, run=4, right -> next x=28 with dir left; x_pos=2, run=5, left -> next x=3 with dir right; x_pos=27, run=4, right -> x=31, no flip.
REQ-031 grav=1, rise=4, x_pos=5, run=0 -> y sequence 0,4,7,9,10,10,9,7,4,0; then DONE, because the next y would be -5; 10 FLY cycles.
REQ-032 rise=0, grav=0, target never reached -> DONE after step 63; hit=0; shoot pulses during FLY are ignored.
REQ-033 rst=0 asynchronously at FLY step 5 -> all outputs 0 before the next clk edge; no result_valid; a new shoot after release launches normally.
REQ-034 Target at the launch point (x_pos,0) -> hit=1 and hit_step=0; a later coincident crossing SHALL NOT change hit_step.
